id_ex_skid: RTL and testbench

Decode-to-execute pipeline stage that registers the ALU operands, the 4-bit ALU opcode and writeback tag, and presents them to the execute-stage ALU. A two-entry skid buffer with valid/ready handshakes on both sides sustains one op per cycle while the execute stage is able to stall it. A synchronous flush removes both entries on branch redirect.

---
 rtl/id_ex_skid_pkg.sv | 35 +++
 rtl/id_ex_skid_payload_reg.sv | 25 ++
 rtl/id_ex_skid.sv | 149 ++++++++++++++
 tb/tb_id_ex_skid.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_pkg.sv
// Shared decode/execute definitions: ALU opcode encodings, datapath widths
// and the payload carried from decode into the execute-stage ALU.
package id_ex_skid_pkg;

    localparam int XLEN = 64;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_MUL    = 4'b1010,
        ALU_MULH   = 4'b1011,
        ALU_DIV    = 4'b1100,
        ALU_REM    = 4'b1101,
        ALU_ADDW   = 4'b1110,
        ALU_PASS_B = 4'b1111
    } alu_op_t;

    typedef struct packed {
        logic [XLEN-1:0] operand1;
        logic [XLEN-1:0] operand2;
        alu_op_t         alu_op;
        logic [REGW-1:0] rd;
        logic            wb_en;
    } ex_payload_t;

    localparam int PAYLOAD_W = $bits(ex_payload_t);

endpackage

// File: rtl/id_ex_skid_payload_reg.sv
// Load-enabled payload register with asynchronous clear; contents are held
// whenever load_i is low, valid or not.
module payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_skid.sv
// Decode-to-execute stage: a two-entry skid buffer (main + skid) that keeps
// one op per cycle flowing while execute stalls, with flush on redirect.
module id_ex_skid
    import id_ex_skid_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid_in,
    output logic            id_ready_out,
    input  logic [XLEN-1:0] id_operand1_in,
    input  logic [XLEN-1:0] id_operand2_in,
    input  logic [3:0]      id_alu_op_in,
    input  logic [REGW-1:0] id_rd_in,
    input  logic            id_wb_en_in,
    input  logic            flush_in,
    output logic            ex_valid_out,
    input  logic            ex_ready_in,
    output logic [XLEN-1:0] ex_operand1_out,
    output logic [XLEN-1:0] ex_operand2_out,
    output logic [3:0]      ex_alu_op_out,
    output logic [REGW-1:0] ex_rd_out,
    output logic            ex_wb_en_out,
    output logic [1:0]      occupancy_out
);

    // The state encoding equals the entry count, so occupancy_out doubles
    // as the observable FSM state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        accept, consume;
    logic        main_load, skid_load, main_from_skid;
    ex_payload_t in_pl, main_d, main_q, skid_q;

    // Handshakes: a transfer happens on a cycle where valid && ready; valid
    // never waits on ready, and id_ready_out depends on state only.
    assign accept  = id_valid_in && id_ready_out;
    assign consume = ex_valid_out && ex_ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    skid_load = 1'b1;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    state_d        = ST_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Redirect wins over everything; an op accepted this cycle is dropped.
        if (flush_in) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_comb begin
        id_ready_out  = 1'b0;
        ex_valid_out  = 1'b0;
        occupancy_out = 2'd0;
        case (state_q)
            ST_EMPTY: begin
                id_ready_out  = 1'b1;
                occupancy_out = 2'd0;
            end
            ST_ONE: begin
                id_ready_out  = 1'b1;
                ex_valid_out  = 1'b1;
                occupancy_out = 2'd1;
            end
            ST_TWO: begin
                ex_valid_out  = 1'b1;
                occupancy_out = 2'd2;
            end
            default: begin
                id_ready_out  = 1'b0;
                ex_valid_out  = 1'b0;
                occupancy_out = 2'd0;
            end
        endcase
    end

    always_comb begin
        in_pl.operand1 = id_operand1_in;
        in_pl.operand2 = id_operand2_in;
        in_pl.alu_op   = alu_op_t'(id_alu_op_in);
        in_pl.rd       = id_rd_in;
        in_pl.wb_en    = id_wb_en_in;
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    payload_reg #(.W(PAYLOAD_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    payload_reg #(.W(PAYLOAD_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .d_i    (in_pl),
        .q_o    (skid_q)
    );

    assign ex_operand1_out = main_q.operand1;
    assign ex_operand2_out = main_q.operand2;
    assign ex_alu_op_out   = main_q.alu_op;
    assign ex_rd_out       = main_q.rd;
    assign ex_wb_en_out    = main_q.wb_en;

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed scenarios plus a long random run checked
// against a capacity-2 FIFO reference model.
module tb_id_ex_skid;
    import id_ex_skid_pkg::*;

    localparam int PW = PAYLOAD_W;

    logic            clk;
    logic            reset;
    logic            id_valid_in;
    logic            id_ready_out;
    logic [XLEN-1:0] id_operand1_in;
    logic [XLEN-1:0] id_operand2_in;
    logic [3:0]      id_alu_op_in;
    logic [REGW-1:0] id_rd_in;
    logic            id_wb_en_in;
    logic            flush_in;
    logic            ex_valid_out;
    logic            ex_ready_in;
    logic [XLEN-1:0] ex_operand1_out;
    logic [XLEN-1:0] ex_operand2_out;
    logic [3:0]      ex_alu_op_out;
    logic [REGW-1:0] ex_rd_out;
    logic            ex_wb_en_out;
    logic [1:0]      occupancy_out;

    logic [PW-1:0] exp_q[$];
    int checks;
    int fails;

    id_ex_skid dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid_in     (id_valid_in),
        .id_ready_out    (id_ready_out),
        .id_operand1_in  (id_operand1_in),
        .id_operand2_in  (id_operand2_in),
        .id_alu_op_in    (id_alu_op_in),
        .id_rd_in        (id_rd_in),
        .id_wb_en_in     (id_wb_en_in),
        .flush_in        (flush_in),
        .ex_valid_out    (ex_valid_out),
        .ex_ready_in     (ex_ready_in),
        .ex_operand1_out (ex_operand1_out),
        .ex_operand2_out (ex_operand2_out),
        .ex_alu_op_out   (ex_alu_op_out),
        .ex_rd_out       (ex_rd_out),
        .ex_wb_en_out    (ex_wb_en_out),
        .occupancy_out   (occupancy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] in_vec();
        return {id_operand1_in, id_operand2_in, id_alu_op_in, id_rd_in, id_wb_en_in};
    endfunction

    function automatic logic [PW-1:0] out_vec();
        return {ex_operand1_out, ex_operand2_out, ex_alu_op_out, ex_rd_out, ex_wb_en_out};
    endfunction

    task automatic drive(input logic v, input logic [XLEN-1:0] o1, input logic [XLEN-1:0] o2,
                         input logic [3:0] op, input logic [REGW-1:0] rd, input logic wb,
                         input logic er, input logic fl);
        id_valid_in    = v;
        id_operand1_in = o1;
        id_operand2_in = o2;
        id_alu_op_in   = op;
        id_rd_in       = rd;
        id_wb_en_in    = wb;
        ex_ready_in    = er;
        flush_in       = fl;
    endtask

    // Model: a FIFO of at most two ops; flush empties it and drops the incoming op.
    task automatic tick();
        bit acc, cons;
        logic [PW-1:0] incoming;
        acc      = id_valid_in && (exp_q.size() < 2);
        cons     = ex_ready_in && (exp_q.size() > 0);
        incoming = in_vec();
        @(posedge clk);
        if (flush_in) begin
            exp_q.delete();
        end else begin
            if (cons) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(incoming);
        end
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ex_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ex_valid_out); end
        checks++; if (id_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", id_ready_out); end
        checks++; if (occupancy_out !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy_out); end
        checks++; if (out_vec() !== '0) begin fails++; $display("FAIL reset_payload: got %h want 0", out_vec()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, XLEN'(i), 64'h0, ALU_ADD, 5'd1, 1'b1, 1'b1, 1'b0);
            tick();
            checks++; if (ex_operand1_out !== XLEN'(i)) begin fails++; $display("FAIL b2b_op1[%0d]: got %0d want %0d", i, ex_operand1_out, i); end
            checks++; if (occupancy_out !== 2'd1 || ex_valid_out !== 1'b1) begin fails++; $display("FAIL b2b_occ[%0d]: got occ=%0d valid=%b want occ=1 valid=1", i, occupancy_out, ex_valid_out); end
        end
        drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (occupancy_out !== 2'd0 || ex_valid_out !== 1'b0) begin fails++; $display("FAIL b2b_drain: got occ=%0d valid=%b want occ=0 valid=0", occupancy_out, ex_valid_out); end
    endtask

    task automatic test_skid();
        logic [XLEN-1:0] seen[$];
        drive(1'b1, 64'd1, 64'h0, ALU_ADD, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'd2, 64'h0, ALU_ADD, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (occupancy_out !== 2'd2) begin fails++; $display("FAIL skid_occ: got %0d want 2", occupancy_out); end
        checks++; if (id_ready_out !== 1'b0) begin fails++; $display("FAIL skid_ready: got %b want 0", id_ready_out); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'd3, 64'h0, ALU_ADD, 5'd2, 1'b1, 1'b0, 1'b0);
            tick();
            checks++; if (occupancy_out !== 2'd2 || ex_operand1_out !== 64'd1) begin fails++; $display("FAIL skid_hold[%0d]: got occ=%0d op1=%0d want occ=2 op1=1", i, occupancy_out, ex_operand1_out); end
        end
        seen.push_back(ex_operand1_out);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'd3, 64'h0, ALU_ADD, 5'd2, 1'b1, 1'b1, 1'b0);
            tick();
            if (ex_valid_out === 1'b1 && ex_operand1_out !== seen[$]) seen.push_back(ex_operand1_out);
            if (exp_q.size() == 0) break;
            if (ex_operand1_out === 64'd3) begin
                drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b0);
                tick();
                break;
            end
        end
        checks++; if (seen.size() != 3 || seen[0] !== 64'd1 || seen[1] !== 64'd2 || seen[2] !== 64'd3) begin fails++; $display("FAIL skid_order: got %0d ops %p want 1,2,3", seen.size(), seen); end
        checks++; if (occupancy_out !== 2'd0) begin fails++; $display("FAIL skid_drain: got occ=%0d want 0", occupancy_out); end
    endtask

    task automatic test_flush();
        drive(1'b1, 64'h10, 64'h0, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h11, 64'h0, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (occupancy_out !== 2'd2) begin fails++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy_out); end
        drive(1'b1, 64'hD, 64'h0, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (ex_valid_out !== 1'b0 || id_ready_out !== 1'b1 || occupancy_out !== 2'd0) begin fails++; $display("FAIL flush_state: got valid=%b ready=%b occ=%0d want 0,1,0", ex_valid_out, id_ready_out, occupancy_out); end
        drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ex_valid_out !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d]: got valid=%b op1=%h want valid=0", i, ex_valid_out, ex_operand1_out); end
        end
    endtask

    task automatic test_pass_through();
        logic [XLEN-1:0] op1;
        op1 = {$urandom, $urandom};
        drive(1'b1, 64'h5, 64'h0, ALU_ADD, 5'd31, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, op1, 64'hFFFF_FFFF_FFFF_FFFF, ALU_SRA, 5'd5, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (occupancy_out !== 2'd1) begin fails++; $display("FAIL pass_occ: got %0d want 1", occupancy_out); end
        checks++; if (ex_operand2_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL pass_op2: got %h want ffffffffffffffff", ex_operand2_out); end
        checks++; if (ex_operand1_out !== op1) begin fails++; $display("FAIL pass_op1: got %h want %h", ex_operand1_out, op1); end
        checks++; if (ex_alu_op_out !== 4'b0111 || ex_rd_out !== 5'd5 || ex_wb_en_out !== 1'b0) begin fails++; $display("FAIL pass_fields: got op=%b rd=%0d wb=%b want 0111,5,0", ex_alu_op_out, ex_rd_out, ex_wb_en_out); end
        drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 64'hA1, 64'hB1, ALU_XOR, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'hA2, 64'hB2, ALU_XOR, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (occupancy_out !== 2'd2) begin fails++; $display("FAIL rst_mid_pre: got occ=%0d want 2", occupancy_out); end
        drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (ex_valid_out !== 1'b0 || id_ready_out !== 1'b1 || occupancy_out !== 2'd0) begin fails++; $display("FAIL rst_mid_state: got valid=%b ready=%b occ=%0d want 0,1,0", ex_valid_out, id_ready_out, occupancy_out); end
        checks++; if (out_vec() !== '0) begin fails++; $display("FAIL rst_mid_payload: got %h want 0", out_vec()); end
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (ex_valid_out !== 1'b0 || occupancy_out !== 2'd0) begin fails++; $display("FAIL rst_mid_after: got valid=%b occ=%0d want 0,0", ex_valid_out, occupancy_out); end
    endtask

    task automatic test_random();
        int bad_state, bad_payload;
        bad_state   = 0;
        bad_payload = 0;
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (ex_valid_out !== (exp_q.size() > 0) || id_ready_out !== (exp_q.size() < 2) ||
                occupancy_out !== 2'(exp_q.size()) || occupancy_out > 2'd2) begin
                fails++;
                if (bad_state < 5) $display("FAIL rand_state@%0d: got valid=%b ready=%b occ=%0d want occ=%0d", c, ex_valid_out, id_ready_out, occupancy_out, exp_q.size());
                bad_state++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (out_vec() !== exp_q[0]) begin
                    fails++;
                    if (bad_payload < 5) $display("FAIL rand_payload@%0d: got %h want %h", c, out_vec(), exp_q[0]);
                    bad_payload++;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        drive(1'b0, 64'h0, 64'h0, ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        test_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_back_to_back();
        test_skid();
        test_flush();
        test_pass_through();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
